// File: rtl/video_timing_gen_pkg.sv
// Shared types, register map and helpers for the raster timing generator.
package video_timing_pkg;

  localparam int CFG_W = 16;

  localparam logic [3:0] REG_HT   = 4'd0;
  localparam logic [3:0] REG_HBS  = 4'd1;
  localparam logic [3:0] REG_HBE  = 4'd2;
  localparam logic [3:0] REG_HSS  = 4'd3;
  localparam logic [3:0] REG_HSE  = 4'd4;
  localparam logic [3:0] REG_VT   = 4'd5;
  localparam logic [3:0] REG_VBS  = 4'd6;
  localparam logic [3:0] REG_VBE  = 4'd7;
  localparam logic [3:0] REG_VSS  = 4'd8;
  localparam logic [3:0] REG_VSE  = 4'd9;
  localparam logic [3:0] REG_VINT = 4'd10;

  // Timing of one axis: last index plus blank and sync windows.
  typedef struct packed {
    logic [CFG_W-1:0] total;
    logic [CFG_W-1:0] bs;
    logic [CFG_W-1:0] be;
    logic [CFG_W-1:0] ss;
    logic [CFG_W-1:0] se;
  } axis_cfg_t;

  // Window membership; S>E wraps around the end of the axis, S==E is empty.
  function automatic logic in_window(input logic [CFG_W-1:0] c,
                                     input logic [CFG_W-1:0] s,
                                     input logic [CFG_W-1:0] e);
    logic r;
    if (s < e) begin
      r = (c >= s) && (c < e);
    end else if (s > e) begin
      r = (c >= s) || (c < e);
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // Keep only the low w bits of a config write.
  function automatic logic [CFG_W-1:0] low_bits(input logic [CFG_W-1:0] d, input int w);
    logic [CFG_W-1:0] m;
    m = ({{(CFG_W-1){1'b0}}, 1'b1} << w) - {{(CFG_W-1){1'b0}}, 1'b1};
    return d & m;
  endfunction

  // Build an axis config from integer parameters.
  function automatic axis_cfg_t make_axis(input int t, input int bs, input int be,
                                          input int ss, input int se);
    axis_cfg_t r;
    r.total = CFG_W'(t);
    r.bs    = CFG_W'(bs);
    r.be    = CFG_W'(be);
    r.ss    = CFG_W'(ss);
    r.se    = CFG_W'(se);
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Configuration port of the timing generator.
interface video_timing_gen_if;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_pending;

  modport master (output cfg_we, output cfg_addr, output cfg_data, input cfg_pending);
  modport slave  (input cfg_we, input cfg_addr, input cfg_data, output cfg_pending);
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// One raster axis: active timing, counter with wrap, windowed blank/sync decode.
// Flags are decoded from the next count against the timing that will govern
// it, so a frame-end load takes effect on the very first position of the frame.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int        W       = 10,
  parameter axis_cfg_t RST_CFG = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         load,
  input  axis_cfg_t    shd_cfg,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         blank,
  output logic         sync
);

  localparam logic BLANK_RST = in_window({CFG_W{1'b0}}, RST_CFG.bs, RST_CFG.be);
  localparam logic SYNC_RST  = in_window({CFG_W{1'b0}}, RST_CFG.ss, RST_CFG.se);

  axis_cfg_t    act_q, act_d;
  logic [W-1:0] count_q, count_d;
  logic         blank_q, blank_d;
  logic         sync_q, sync_d;

  assign wrap  = (CFG_W'(count_q) == act_q.total);
  assign count = count_q;
  assign blank = blank_q;
  assign sync  = sync_q;

  // Next count, next active timing and flags decoded from the next count.
  always_comb begin
    act_d   = act_q;
    count_d = count_q;
    blank_d = blank_q;
    sync_d  = sync_q;
    if (adv) begin
      if (load) begin
        act_d = shd_cfg;
      end else begin
        act_d = act_q;
      end
      if (wrap) begin
        count_d = {W{1'b0}};
      end else begin
        count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
      blank_d = in_window(CFG_W'(count_d), act_d.bs, act_d.be);
      sync_d  = in_window(CFG_W'(count_d), act_d.ss, act_d.se);
    end else begin
      act_d   = act_q;
      count_d = count_q;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q   <= RST_CFG;
      count_q <= {W{1'b0}};
      blank_q <= BLANK_RST;
      sync_q  <= SYNC_RST;
    end else begin
      act_q   <= act_d;
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: shadowed timing registers applied at
// end of frame, H/V axes, frame-start strobe and raster-compare line interrupt.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HW          = 10,
  parameter int VW          = 9,
  parameter int H_TOTAL_DEF = 511,
  parameter int H_BS_DEF    = 384,
  parameter int H_BE_DEF    = 0,
  parameter int H_SS_DEF    = 416,
  parameter int H_SE_DEF    = 448,
  parameter int V_TOTAL_DEF = 283,
  parameter int V_BS_DEF    = 256,
  parameter int V_BE_DEF    = 16,
  parameter int V_SS_DEF    = 264,
  parameter int V_SE_DEF    = 268,
  parameter int V_INT_DEF   = 511
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_pix,
  video_timing_gen_if.slave   cfg,
  output logic [HW-1:0]       hcount,
  output logic [VW-1:0]       vcount,
  output logic                hblank,
  output logic                vblank,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start,
  output logic                line_irq
);

  localparam axis_cfg_t H_RST = make_axis(H_TOTAL_DEF, H_BS_DEF, H_BE_DEF, H_SS_DEF, H_SE_DEF);
  localparam axis_cfg_t V_RST = make_axis(V_TOTAL_DEF, V_BS_DEF, V_BE_DEF, V_SS_DEF, V_SE_DEF);
  localparam logic [CFG_W-1:0] VINT_RST = CFG_W'(V_INT_DEF);

  logic             h_wrap, v_wrap, eof, apply;
  logic [VW-1:0]    v_line_nxt;
  logic [CFG_W-1:0] h_wdata, v_wdata;

  axis_cfg_t        h_shd_q, h_shd_d;
  axis_cfg_t        v_shd_q, v_shd_d;
  logic [CFG_W-1:0] vint_q, vint_d;
  logic             pending_q, pending_d;
  logic             frame_start_q, frame_start_d;
  logic             line_irq_q, line_irq_d;

  // End of frame is the pixel edge leaving the last pixel of the last line.
  assign eof   = ce_pix & h_wrap & v_wrap;
  assign apply = eof & pending_q;

  assign h_wdata = low_bits(cfg.cfg_data, HW);
  assign v_wdata = low_bits(cfg.cfg_data, VW);

  timing_axis #(.W(HW), .RST_CFG(H_RST)) u_h_axis (
    .clk    (clk),
    .rst    (reset),
    .adv    (ce_pix),
    .load   (apply),
    .shd_cfg(h_shd_q),
    .count  (hcount),
    .wrap   (h_wrap),
    .blank  (hblank),
    .sync   (hsync)
  );

  timing_axis #(.W(VW), .RST_CFG(V_RST)) u_v_axis (
    .clk    (clk),
    .rst    (reset),
    .adv    (ce_pix & h_wrap),
    .load   (apply),
    .shd_cfg(v_shd_q),
    .count  (vcount),
    .wrap   (v_wrap),
    .blank  (vblank),
    .sync   (vsync)
  );

  // Shadow writes, direct VINT write and pending flag; a write on the apply
  // edge lands after the old shadow was consumed and keeps pending set.
  always_comb begin
    h_shd_d   = h_shd_q;
    v_shd_d   = v_shd_q;
    vint_d    = vint_q;
    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        REG_HT:   begin h_shd_d.total = h_wdata; pending_d = 1'b1; end
        REG_HBS:  begin h_shd_d.bs    = h_wdata; pending_d = 1'b1; end
        REG_HBE:  begin h_shd_d.be    = h_wdata; pending_d = 1'b1; end
        REG_HSS:  begin h_shd_d.ss    = h_wdata; pending_d = 1'b1; end
        REG_HSE:  begin h_shd_d.se    = h_wdata; pending_d = 1'b1; end
        REG_VT:   begin v_shd_d.total = v_wdata; pending_d = 1'b1; end
        REG_VBS:  begin v_shd_d.bs    = v_wdata; pending_d = 1'b1; end
        REG_VBE:  begin v_shd_d.be    = v_wdata; pending_d = 1'b1; end
        REG_VSS:  begin v_shd_d.ss    = v_wdata; pending_d = 1'b1; end
        REG_VSE:  begin v_shd_d.se    = v_wdata; pending_d = 1'b1; end
        REG_VINT: begin vint_d        = v_wdata; end
        default:  begin vint_d        = vint_q;  end
      endcase
    end else begin
      vint_d = vint_q;
    end
  end

  // Strobes for the position the coming pixel edge loads.
  always_comb begin
    frame_start_d = eof;
    line_irq_d    = 1'b0;
    v_line_nxt    = vcount;
    if (v_wrap) begin
      v_line_nxt = {VW{1'b0}};
    end else begin
      v_line_nxt = vcount + {{(VW-1){1'b0}}, 1'b1};
    end
    if (ce_pix && h_wrap) begin
      line_irq_d = (CFG_W'(v_line_nxt) == vint_q);
    end else begin
      line_irq_d = 1'b0;
    end
  end

  // Config and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_shd_q       <= H_RST;
      v_shd_q       <= V_RST;
      vint_q        <= VINT_RST;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      line_irq_q    <= 1'b0;
    end else begin
      h_shd_q       <= h_shd_d;
      v_shd_q       <= v_shd_d;
      vint_q        <= vint_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      line_irq_q    <= line_irq_d;
    end
  end

  assign cfg.cfg_pending = pending_q;
  assign frame_start     = frame_start_q;
  assign line_irq        = line_irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. The main instance uses scaled-down defaults so
// whole frames fit a short run; a second instance with the real defaults is
// checked over its first lines. The model tracks the pixel index within the
// frame and derives h/v by division against the active totals.
module tb_video_timing_gen;

  localparam int HW = 10;
  localparam int VW = 9;
  localparam int HT0 = 63, HBS0 = 48, HBE0 = 0, HSS0 = 52, HSE0 = 56;
  localparam int VT0 = 35, VBS0 = 32, VBE0 = 4, VSS0 = 33, VSE0 = 34;
  localparam int VINT0 = 511;

  logic clk = 1'b0;
  logic reset, rst2, ce_pix;
  always #5 clk = ~clk;

  video_timing_gen_if cif();
  video_timing_gen_if dif();

  logic [HW-1:0] hcount, d_hcount;
  logic [VW-1:0] vcount, d_vcount;
  logic hblank, vblank, hsync, vsync, frame_start, line_irq;
  logic d_hblank, d_vblank, d_hsync, d_vsync, d_frame_start, d_line_irq;

  video_timing_gen #(
    .HW(HW), .VW(VW),
    .H_TOTAL_DEF(HT0), .H_BS_DEF(HBS0), .H_BE_DEF(HBE0), .H_SS_DEF(HSS0), .H_SE_DEF(HSE0),
    .V_TOTAL_DEF(VT0), .V_BS_DEF(VBS0), .V_BE_DEF(VBE0), .V_SS_DEF(VSS0), .V_SE_DEF(VSE0),
    .V_INT_DEF(VINT0)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .cfg(cif),
    .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .line_irq(line_irq)
  );

  video_timing_gen dut_def (
    .clk(clk), .reset(rst2), .ce_pix(1'b1), .cfg(dif),
    .hcount(d_hcount), .vcount(d_vcount), .hblank(d_hblank), .vblank(d_vblank),
    .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_frame_start), .line_irq(d_line_irq)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int act[10];
  int shd[10];
  int defs[10];
  int pend, vint, p;
  bit efs, eli;

  // measurement helpers
  int cyc_n, maxh, cnt_hb, cnt_li, cnt_fs;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit win(input int c, input int s, input int e);
    if (s < e) return (c >= s) && (c < e);
    if (s > e) return (c >= s) || (c < e);
    return 1'b0;
  endfunction

  function automatic int frame_len();
    return (act[0] + 1) * (act[5] + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      act[i] = defs[i];
      shd[i] = defs[i];
    end
    pend = 0; vint = VINT0; p = 0; efs = 1'b0; eli = 1'b0;
  endtask

  task automatic model_step(input bit ce, input bit we, input int addr, input int data);
    efs = 1'b0; eli = 1'b0;
    if (ce) begin
      p++;
      if (p == frame_len()) begin
        p = 0;
        efs = 1'b1;
        if (pend != 0) begin
          for (int i = 0; i < 10; i++) act[i] = shd[i];
          pend = 0;
        end
      end
      if ((p % (act[0] + 1)) == 0 && (p / (act[0] + 1)) == vint) eli = 1'b1;
    end
    if (we) begin
      if (addr <= 9) begin
        shd[addr] = data % ((addr <= 4) ? (1 << HW) : (1 << VW));
        pend = 1;
      end else if (addr == 10) begin
        vint = data % (1 << VW);
      end
    end
  endtask

  task automatic check_all();
    int hh, vv;
    hh = p % (act[0] + 1);
    vv = p / (act[0] + 1);
    chk("hcount", hcount, hh);
    chk("vcount", vcount, vv);
    chk("hblank", hblank, win(hh, act[1], act[2]));
    chk("hsync", hsync, win(hh, act[3], act[4]));
    chk("vblank", vblank, win(vv, act[6], act[7]));
    chk("vsync", vsync, win(vv, act[8], act[9]));
    chk("frame_start", frame_start, efs);
    chk("line_irq", line_irq, eli);
    chk("cfg_pending", cif.cfg_pending, pend);
  endtask

  task automatic cyc(input bit ce, input bit we, input int addr, input int data);
    ce_pix = ce;
    cif.cfg_we = we;
    cif.cfg_addr = addr[3:0];
    cif.cfg_data = data[15:0];
    @(posedge clk);
    model_step(ce, we, addr, data);
    #1;
    check_all();
    cyc_n++;
    if (int'(hcount) > maxh) maxh = int'(hcount);
    cnt_hb += int'(hblank);
    cnt_li += int'(line_irq);
    cnt_fs += int'(frame_start);
    @(negedge clk);
    ce_pix = 1'b0;
    cif.cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
  endtask

  task automatic wr(input int addr, input int data);
    cyc(1'b1, 1'b1, addr, data);
  endtask

  task automatic run_to_fs(input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (frame_start === 1'b1) break;
    end
    chk("fs_reached", frame_start, 1);
  endtask

  // Real-default instance: h/v follow the free-running pixel count.
  initial begin : def_check
    int hh, vv;
    @(negedge rst2);
    #1;
    chk("def_rst_hcount", d_hcount, 0);
    chk("def_rst_vblank", d_vblank, 1);
    chk("def_rst_hblank", d_hblank, 0);
    chk("def_rst_hsync", d_hsync, 0);
    for (int n = 1; n <= 1100; n++) begin
      @(posedge clk);
      #1;
      hh = n % 512;
      vv = n / 512;
      chk("def_hcount", d_hcount, hh);
      chk("def_vcount", d_vcount, vv);
      chk("def_hsync", d_hsync, (hh >= 416 && hh <= 447) ? 1 : 0);
      chk("def_hblank", d_hblank, (hh >= 384) ? 1 : 0);
      chk("def_vblank", d_vblank, (vv < 16) ? 1 : 0);
      chk("def_vsync", d_vsync, 0);
      chk("def_pulses", {d_frame_start, d_line_irq}, 0);
      if (n == 512) chk("def_wrap_512", {22'd0, d_hcount}, 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pick, a, d, lo, hi;
    int rand_addr[10];
    rand_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10};
    defs = '{HT0, HBS0, HBE0, HSS0, HSE0, VT0, VBS0, VBE0, VSS0, VSE0};
    reset = 1'b1; rst2 = 1'b1; ce_pix = 1'b0;
    cif.cfg_we = 1'b0; cif.cfg_addr = 4'd0; cif.cfg_data = 16'd0;
    dif.cfg_we = 1'b0; dif.cfg_addr = 4'd0; dif.cfg_data = 16'd0;
    cyc_n = 0; maxh = 0; cnt_hb = 0; cnt_li = 0; cnt_fs = 0;
    #12 rst2 = 1'b0;
    @(negedge clk);
    model_reset();
    check_all();
    chk("rst_vblank_lit", vblank, 1);
    chk("rst_hblank_lit", hblank, 0);
    reset = 1'b0;

    // defaults: frame period
    cyc_n = 0; run_to_fs(3000);
    chk("fs_first_lit", cyc_n, 2304);
    cyc_n = 0; run_to_fs(3000);
    chk("fs_period_lit", cyc_n, 2304);

    // wrap-around h-blank window
    run(77);
    wr(1, 60);
    chk("pend_after_wr_lit", cif.cfg_pending, 1);
    wr(2, 10);
    run_to_fs(3000);
    cnt_hb = 0; run(2304);
    chk("hblank_count_lit", cnt_hb, 14 * 36);

    // HT change mid-frame
    run(100);
    wr(0, 47);
    chk("pend_ht_lit", cif.cfg_pending, 1);
    maxh = 0; run_to_fs(3000);
    chk("maxh_old_lit", maxh, 63);
    chk("pend_clear_lit", cif.cfg_pending, 0);
    maxh = 0; run(48 * 36);
    chk("maxh_new_lit", maxh, 47);
    chk("fs_ht47_lit", frame_start, 1);

    // write colliding with the apply edge
    run(50);
    wr(0, 55);
    for (int i = 0; i < 5000 && p != frame_len() - 1; i++) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 0, 39);
    chk("coll_fs_lit", frame_start, 1);
    chk("coll_pend_lit", cif.cfg_pending, 1);
    maxh = 0; cyc_n = 0; run_to_fs(5000);
    chk("coll_len_lit", cyc_n, 56 * 36);
    chk("coll_maxh_lit", maxh, 55);
    chk("coll_pend_clr_lit", cif.cfg_pending, 0);
    maxh = 0; run(40 * 36);
    chk("coll_maxh2_lit", maxh, 39);

    // raster-compare interrupt
    run(20);
    wr(10, 10);
    cnt_li = 0; run(40 * 36);
    chk("irq_once_lit", cnt_li, 1);
    wr(10, 300);
    cnt_li = 0; run(40 * 36);
    chk("irq_never_lit", cnt_li, 0);

    // ce_pix every 4th cycle with random config traffic
    cnt_fs = 0;
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(0, 127) == 0) begin
        pick = $urandom_range(0, 9);
        a = rand_addr[pick];
        if (a == 0) begin lo = 20; hi = 47; end
        else if (a == 5) begin lo = 10; hi = 35; end
        else if (a <= 4) begin lo = 0; hi = 70; end
        else begin lo = 0; hi = 40; end
        d = $urandom_range(lo, hi);
        cyc((i % 4) == 0, 1'b1, a, d);
      end else begin
        cyc((i % 4) == 0, 1'b0, 0, 0);
      end
    end
    chk("ce4_fs_seen", (cnt_fs > 0) ? 1 : 0, 1);

    // async reset mid-frame with a pending write
    run(300);
    wr(0, 20);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("areset_h_lit", hcount, 0);
    chk("areset_pend_lit", cif.cfg_pending, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc_n = 0; run_to_fs(3000);
    chk("post_rst_fs_lit", cyc_n, 2304);
    maxh = 0; run(200);
    chk("post_rst_maxh_lit", maxh, 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator that replaces the fixed vertical-decode lookup with programmable horizontal and vertical counters and windowed decode of blank/sync flags. Timing registers are loaded through a small config port, shadowed, and applied atomically at end of frame. A raster-compare line interrupt and a frame-start strobe are provided. The block sits between the pixel clock-enable source and the tilemap, sprite and video-output stages, all of which consume its counters and flags.

## Interface
- HW, 10, horizontal counter width.
- VW, 9, vertical counter width.
- H_TOTAL_DEF, 511, reset last-pixel index.
- H_BS_DEF / H_BE_DEF, 384 / 0, reset h-blank start / end.
- H_SS_DEF / H_SE_DEF, 416 / 448, reset h-sync start / end.
- V_TOTAL_DEF, 283, reset last-line index.
- V_BS_DEF / V_BE_DEF, 256 / 16, reset v-blank start / end.
- V_SS_DEF / V_SE_DEF, 264 / 268, reset v-sync start / end.
- V_INT_DEF, 511, reset interrupt line.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pixel clock enable; all counting happens only on ce_pix.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  register select: 0 HT, 1 HBS, 2 HBE, 3 HSS, 4 HSE, 5 VT, 6 VBS, 7 VBE, 8 VSS, 9 VSE, 10 VINT; 11-15 ignored.
- cfg_data  in  16  write data; low HW or VW bits used.
- cfg_pending  out  1  shadowed write not yet applied.
- hcount  out  HW  current pixel index.
- vcount  out  VW  current line index.
- hblank, vblank, hsync, vsync  out  1  decoded window flags.
- frame_start  out  1  one-cycle pulse at (0,0).
- line_irq  out  1  one-cycle pulse at hcount 0 of line VINT.

## Operation
- Active set: HT..VSE. Shadow set: same registers, written by cfg_we. VINT has no shadow; it is written directly to the active set and takes effect immediately.
- hcount increments on ce_pix and wraps to 0 when equal to the active HT. vcount increments on that wrap and wraps to 0 when equal to the active VT.
- End of frame is ce_pix with hcount==HT and vcount==VT. At that edge: both counters go to 0, and if cfg_pending is set, shadow copies to active and cfg_pending clears.
- cfg_we in the same cycle as an apply: the apply uses the old shadow, the new write lands in the shadow, and cfg_pending stays 1.
- Window decode for flag f with start S and end E, on count c:
  - S<=E: f = S<=c<E.
  - S>E: f = c>=S or c<E (wrap window).
  - S==E: f never asserts.
- Flags are decoded from the next counter value and registered with it, so flags always match the hcount/vcount on the same cycle.
- frame_start and line_irq assert for exactly one clk cycle, on the ce_pix edge that loads the matching position. They are 0 on all other cycles.
- A VINT greater than VT never fires.
- Reset values: counters 0; active and shadow sets = *_DEF; cfg_pending 0; frame_start and line_irq 0. hblank, hsync, vblank and vsync take the decode of (0,0) against the defaults, i.e. vblank 1 and the others 0.

## Timing
- Counter/flag latency: 1 clk after the ce_pix edge. No output changes without ce_pix, except on reset.
- Config writes: 1 clk to the shadow. cfg_pending rises the cycle after cfg_we.
- Apply: shadow values govern decode starting at (0,0) of the next frame.
- Asserting reset mid-frame immediately forces all reset values. Shadow contents and pending writes are discarded.
- ce_pix held high continuously: one pixel per clk. Gaps in ce_pix freeze all state.

## Structure
- Shared package video_timing_pkg holds:
  - register address constants (REG_HT..REG_VINT);
  - a struct for one axis {total, bs, be, ss, se}.
- One sub-module, timing_axis: counter, wrap compare, and windowed decode for a single axis, instantiated for H (HW) and V (VW).
- The top level holds the config file, shadow/apply logic, and the pulse outputs.

## Test plan
- Reset defaults, ce_pix every cycle:
  - hcount wraps 511→0 after 512 cycles.
  - vcount wraps 283→0 after 284 lines.
  - frame_start period is 145408 clk.
  - hsync is high for hcount 416-447.
- Wrap window: vblank is 1 for vcount 256-283 and 0-15, and 0 for vcount 16-255. Set HBS=500, HBE=10 → hblank is 1 for hcount 500-511 and 0-9.
- Write HT=383 mid-frame:
  - cfg_pending goes to 1.
  - hcount keeps wrapping at 511 until end of frame.
  - From the next frame, hcount wraps at 383 and cfg_pending is 0.
- Write collides with the apply cycle (cfg_we at the end-of-frame ce_pix): the old shadow is applied, the new value is applied one frame later, and cfg_pending stays 1 in between.
- VINT=100 written mid-frame:
  - line_irq is a single 1-clk pulse at (0,100) in the current frame if still ahead of the raster.
  - VINT=300 never pulses.
- Reset asserted at (200,150) with a pending write: all outputs return to reset values asynchronously, and the write is never applied.
- ce_pix every 4th cycle: outputs change only one clk after a ce_pix edge, and frame_start is still a single-clk pulse.
